// File: rtl/reg_file_2r1w_if.sv
// Operand-fetch / writeback bus of the 2-read 1-write register file.
// master = core side (decode + writeback), slave = register file.
interface reg_file_2r1w_if #(
    parameter int XLEN = 64,
    parameter int AW   = 5
);
    logic            rd_en;
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            rd_valid;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;
    logic            busy;

    modport master (
        output rd_en, rs1_addr, rs2_addr, wr_en, wr_addr, wr_data,
        input  rs1_data, rs2_data, rd_valid, busy
    );

    modport slave (
        input  rd_en, rs1_addr, rs2_addr, wr_en, wr_addr, wr_data,
        output rs1_data, rs2_data, rd_valid, busy
    );
endinterface

// File: rtl/reg_file_2r1w.sv
// Two registered read ports, one write port, optional hardwired-zero r0,
// write-to-read bypass and a sequential clear of the array after reset.
module reg_file_2r1w #(
    parameter int XLEN     = 64,
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic            clk,
    input  logic            rst,
    reg_file_2r1w_if.slave  bus
);

    localparam bit HAS_ZERO = (ZERO_REG != 0);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [AW-1:0]   clr_ptr_reg;
    logic [AW-1:0]   clr_ptr_next;

    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] regs_mem [NREG];

    logic            wr_accept;
    logic            rd_accept;
    logic            rd_valid_reg;

    // A write to r0 is dropped entirely, so it can neither land nor bypass.
    assign wr_accept = bus.wr_en && !(HAS_ZERO && (bus.wr_addr == '0));
    assign rd_accept = (state_reg == ST_RUN) && bus.rd_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_CLEAR;
            clr_ptr_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_ptr_reg <= clr_ptr_next;
        end
    end

    // The single array write port is shared between the clear sweep and the core.
    always_comb begin
        state_next   = state_reg;
        clr_ptr_next = clr_ptr_reg;
        mem_we       = 1'b0;
        mem_waddr    = bus.wr_addr;
        mem_wdata    = bus.wr_data;
        case (state_reg)
            ST_CLEAR: begin
                mem_we       = 1'b1;
                mem_waddr    = clr_ptr_reg;
                mem_wdata    = '0;
                clr_ptr_next = clr_ptr_reg + AW'(1);
                if (clr_ptr_reg == AW'(NREG - 1)) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                mem_we = wr_accept;
            end
            default: begin
                state_next   = ST_CLEAR;
                clr_ptr_next = '0;
            end
        endcase
        if (rst) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            regs_mem[mem_waddr] <= mem_wdata;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [AW-1:0]   addr;
            logic [XLEN-1:0] value_next;
            logic [XLEN-1:0] data_reg;

            assign addr = (gi == 0) ? bus.rs1_addr : bus.rs2_addr;

            always_comb begin
                value_next = regs_mem[addr];
                if (HAS_ZERO && (addr == '0)) begin
                    value_next = '0;
                end else if (wr_accept && (bus.wr_addr == addr)) begin
                    value_next = bus.wr_data;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    data_reg <= '0;
                end else if (rd_accept) begin
                    data_reg <= value_next;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= rd_accept;
        end
    end

    assign bus.rs1_data = g_port[0].data_reg;
    assign bus.rs2_data = g_port[1].data_reg;
    assign bus.rd_valid = rd_valid_reg;
    assign bus.busy     = (state_reg == ST_CLEAR);

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Scoreboard bench: stimulus pushes expected read results from an array model,
// an independent monitor pops them whenever rd_valid is seen.
module tb_reg_file_2r1w;
    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_file_2r1w_if #(.XLEN(XLEN), .AW(AW)) bus ();

    reg_file_2r1w #(
        .XLEN(XLEN), .NREG(NREG), .AW(AW), .ZERO_REG(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [XLEN-1:0] d1;
        logic [XLEN-1:0] d2;
        logic [AW-1:0]   a1;
        logic [AW-1:0]   a2;
        int              issue;
    } exp_t;

    int checks   = 0;
    int failures = 0;
    int cyc_cnt  = 0;
    exp_t exp_q[$];
    logic [XLEN-1:0] mem_m [NREG];
    int  clr_left = -1;   // cycles of clear still to go; -1 before first reset
    bit  prev_rst = 1'b0;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] ref_read(input logic [AW-1:0] a, input logic we,
                                                 input logic [AW-1:0] wa, input logic [XLEN-1:0] wd);
        if (a == 0) return '0;
        if (we && wa == a) return wd;
        return mem_m[a];
    endfunction

    // One clock cycle: check visible state, drive inputs, update the model.
    task automatic step(input logic r, input logic re, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                        input logic we, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd);
        exp_t e;
        if (clr_left >= 0) check("busy", {63'd0, bus.busy}, {63'd0, clr_left > 0});
        if (prev_rst) begin
            check("rst_rs1_data", bus.rs1_data, '0);
            check("rst_rs2_data", bus.rs2_data, '0);
            check("rst_rd_valid", {63'd0, bus.rd_valid}, '0);
        end
        rst          = r;
        bus.rd_en    = re;
        bus.rs1_addr = a1;
        bus.rs2_addr = a2;
        bus.wr_en    = we;
        bus.wr_addr  = wa;
        bus.wr_data  = wd;
        if (r) begin
            clr_left = NREG;
            foreach (mem_m[i]) mem_m[i] = '0;
        end else if (clr_left > 0) begin
            clr_left--;
        end else if (clr_left == 0) begin
            if (re) begin
                e.d1 = ref_read(a1, we, wa, wd);
                e.d2 = ref_read(a2, we, wa, wd);
                e.a1 = a1;
                e.a2 = a2;
                e.issue = cyc_cnt;
                exp_q.push_back(e);
            end
            if (we && wa != 0) mem_m[wa] = wd;
        end
        prev_rst = r;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        step(1'b0, 1'b0, '0, '0, 1'b1, a, d);
    endtask

    task automatic rd(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        step(1'b0, 1'b1, a1, a2, 1'b0, '0, '0);
    endtask

    // Monitor
    always @(posedge clk) begin
        exp_t e;
        cyc_cnt++;
        #1;
        if (bus.rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rd_valid: got rd_valid=1 expected no response (t=%0t)", $time);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("rs1_data[%0d]", e.a1), bus.rs1_data, e.d1);
                check($sformatf("rs2_data[%0d]", e.a2), bus.rs2_data, e.d2);
                check("read_latency", 64'(cyc_cnt), 64'(e.issue + 1));
            end
        end
    end

    initial begin
        logic [AW-1:0]   ra1, ra2, rwa;
        logic [XLEN-1:0] rwd;
        logic            rre, rwe;

        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);

        // Requests during clear must be ignored
        step(1'b0, 1'b1, 5'd3, 5'd3, 1'b1, 5'd3, 64'h55);
        step(1'b0, 1'b1, 5'd3, 5'd4, 1'b1, 5'd3, 64'h55);
        repeat (NREG - 1) idle();

        for (int i = 1; i < NREG; i++) rd(AW'(i), AW'((i + 1) % NREG));

        wr(5'd5, 64'h0000_0000_DEAD_BEEF);
        rd(5'd5, 5'd6);

        wr(5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        rd(5'd0, 5'd0);
        step(1'b0, 1'b1, 5'd0, 5'd5, 1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF);

        wr(5'd7, 64'h11);
        step(1'b0, 1'b1, 5'd7, 5'd7, 1'b1, 5'd7, 64'h22);
        rd(5'd7, 5'd0);
        idle();
        rd(5'd7, 5'd7);

        for (int n = 0; n < 300; n++) begin
            rre = 1'($urandom_range(0, 3) != 0);
            rwe = 1'($urandom_range(0, 1));
            rwa = AW'($urandom_range(0, NREG - 1));
            ra1 = ($urandom_range(0, 3) == 0) ? rwa : AW'($urandom_range(0, NREG - 1));
            ra2 = ($urandom_range(0, 3) == 0) ? rwa : AW'($urandom_range(0, NREG - 1));
            rwd = {$urandom, $urandom};
            step(1'b0, rre, ra1, ra2, rwe, rwa, rwd);
        end

        // Reset arriving together with a read
        wr(5'd9, 64'h99);
        step(1'b1, 1'b1, 5'd9, 5'd9, 1'b0, '0, '0);
        repeat (NREG) idle();
        rd(5'd9, 5'd9);
        repeat (3) idle();

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_responses: got %0d outstanding expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
